// File: rtl/svm_mac_pe_if.sv
// svm_mac_pe_if: the feature/coefficient bus of one SVM MAC processing element.
//
// Signals (W = FEA_I + FEA_F, lane k of a 9*W vector sits at [k*W +: W]):
//   fea_a..fea_d    9*W  HOG feature vectors, Q(FEA_I.FEA_F) per lane
//   coef_a..coef_d  9*W  SVM coefficients paired lane-by-lane with fea_x
//   i_data          W    upstream partial sum (0 for the first PE)
//   i_valid         1    qualifies an update this cycle
//   o_data          W    registered partial sum to the downstream PE
//
// master: the upstream side that drives features and sees o_data.
// slave : the processing element itself.
interface svm_mac_pe_if #(
  parameter int FEA_I = 4,
  parameter int FEA_F = 28
);
  localparam int W = FEA_I + FEA_F;

  logic [9*W-1:0] fea_a;
  logic [9*W-1:0] fea_b;
  logic [9*W-1:0] fea_c;
  logic [9*W-1:0] fea_d;
  logic [9*W-1:0] coef_a;
  logic [9*W-1:0] coef_b;
  logic [9*W-1:0] coef_c;
  logic [9*W-1:0] coef_d;
  logic [W-1:0]   i_data;
  logic           i_valid;
  logic [W-1:0]   o_data;

  modport master (
    output fea_a, fea_b, fea_c, fea_d,
    output coef_a, coef_b, coef_c, coef_d,
    output i_data, i_valid,
    input  o_data
  );

  modport slave (
    input  fea_a, fea_b, fea_c, fea_d,
    input  coef_a, coef_b, coef_c, coef_d,
    input  i_data, i_valid,
    output o_data
  );
endinterface

// File: rtl/svm_mac_pe.sv
// svm_mac_pe: one processing element of the SVM human-detection systolic chain.
//
// Each valid cycle it forms the 36-term dot product of four 9-lane feature
// vectors with their coefficient vectors, adds the upstream partial sum,
// requantises back to Q(FEA_I.FEA_F) (floor, then saturate) and registers it.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset; clears o_data
//   bus   slave modport of svm_mac_pe_if (features, coefficients,
//              i_data, i_valid in; o_data out)
module svm_mac_pe #(
  parameter int FEA_I = 4,
  parameter int FEA_F = 28
) (
  input  logic         clk,
  input  logic         rst,
  svm_mac_pe_if.slave  bus
);
  localparam int W     = FEA_I + FEA_F;
  localparam int PW    = 2 * W;
  // 36 products of at most 2^(2W-2) magnitude plus the aligned offset need
  // 2W+5 bits signed; one extra bit of margin.
  localparam int ACC_W = 2 * W + 6;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  // Exact sum of the 9 lane products of one vector pair.
  function automatic logic signed [ACC_W-1:0] dot9(
    input logic [9*W-1:0] fea,
    input logic [9*W-1:0] coef
  );
    logic signed [PW-1:0]    f;
    logic signed [PW-1:0]    c;
    logic signed [PW-1:0]    p;
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      f   = {{W{fea[k*W+W-1]}}, fea[k*W +: W]};
      c   = {{W{coef[k*W+W-1]}}, coef[k*W +: W]};
      // The full product of two W-bit signed values always fits in 2W bits.
      p   = f * c;
      acc = acc + {{(ACC_W-PW){p[PW-1]}}, p};
    end
    return acc;
  endfunction

  logic signed [ACC_W-1:0] offset;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [W-1:0]            next_data;

  always_comb begin
    // Upstream sum is Q(I.F); move it to the Q(2I.2F) product scale.
    offset  = {{(ACC_W-W-FEA_F){bus.i_data[W-1]}}, bus.i_data, {FEA_F{1'b0}}};
    sum     = dot9(bus.fea_a, bus.coef_a) + dot9(bus.fea_b, bus.coef_b)
            + dot9(bus.fea_c, bus.coef_c) + dot9(bus.fea_d, bus.coef_d)
            + offset;
    shifted = sum >>> FEA_F;
    if (shifted > SAT_MAX) begin
      next_data = {1'b0, {(W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      next_data = {1'b1, {(W-1){1'b0}}};
    end else begin
      next_data = shifted[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.o_data <= '0;
    end else if (bus.i_valid) begin
      bus.o_data <= next_data;
    end
  end
endmodule

// File: tb/tb_svm_mac_pe.sv
// Testbench for svm_mac_pe: directed cases with known results, then random
// stimulus scored against an arbitrary-precision reference model.
module tb_svm_mac_pe;
  localparam int FEA_I = 4;
  localparam int FEA_F = 28;
  localparam int W     = FEA_I + FEA_F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  svm_mac_pe_if #(.FEA_I(FEA_I), .FEA_F(FEA_F)) bus ();

  svm_mac_pe #(.FEA_I(FEA_I), .FEA_F(FEA_F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] fe [4][9];
  logic [W-1:0] cf [4][9];
  logic [W-1:0] idat;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] model_q = '0;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic signed [127:0] ONE  = 128'sd268435456;
  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

  function automatic logic signed [127:0] sx(input logic [W-1:0] v);
    return {{(128-W){v[W-1]}}, v};
  endfunction

  // Real-valued rule: value = raw / 2^28; result = clamp(floor(sum)).
  function automatic logic [W-1:0] ref_model();
    logic signed [127:0] s, q, r;
    s = sx(idat) * ONE;
    for (int x = 0; x < 4; x++)
      for (int k = 0; k < 9; k++)
        s = s + sx(fe[x][k]) * sx(cf[x][k]);
    q = s / ONE;
    r = s % ONE;
    if (s < 0 && r != 0) q = q - 1;
    if (q > MAXV) return 32'h7FFF_FFFF;
    if (q < MINV) return 32'h8000_0000;
    return q[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic clear();
    for (int x = 0; x < 4; x++)
      for (int k = 0; k < 9; k++) begin
        fe[x][k] = '0;
        cf[x][k] = '0;
      end
    idat = '0;
  endtask

  task automatic issue(input logic v, input logic use_exp, input logic [W-1:0] e);
    for (int k = 0; k < 9; k++) begin
      bus.fea_a[k*W +: W]  = fe[0][k];
      bus.fea_b[k*W +: W]  = fe[1][k];
      bus.fea_c[k*W +: W]  = fe[2][k];
      bus.fea_d[k*W +: W]  = fe[3][k];
      bus.coef_a[k*W +: W] = cf[0][k];
      bus.coef_b[k*W +: W] = cf[1][k];
      bus.coef_c[k*W +: W] = cf[2][k];
      bus.coef_d[k*W +: W] = cf[3][k];
    end
    bus.i_data  = idat;
    bus.i_valid = v;
    if (v && rst) exp_q.push_back(use_exp ? e : ref_model());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input logic [W-1:0] fv, input logic [W-1:0] cv);
    for (int x = 0; x < 4; x++)
      for (int k = 0; k < 9; k++) begin
        fe[x][k] = fv;
        cf[x][k] = cv;
      end
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic signed [W-1:0] t;
    t = $urandom;
    if ($urandom_range(0, 4) == 0) return '0;
    return t >>> $urandom_range(0, 31);
  endfunction

  task automatic randomize_inputs();
    for (int x = 0; x < 4; x++)
      for (int k = 0; k < 9; k++) begin
        fe[x][k] = rnd_val();
        cf[x][k] = rnd_val();
      end
    idat = rnd_val();
  endtask

  // Monitor: o_data updates on every accepted cycle; pop the expected value
  // at that edge and compare on the following falling edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q = '0;
    end else if (bus.i_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        model_q = exp_q.pop_front();
      end
    end
  end

  always @(negedge clk) check("o_data", bus.o_data, model_q);

  initial begin
    clear();
    issue(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", bus.o_data, '0);
    rst = 1'b1;

    clear(); idat = 32'h1234_5678;
    issue(1'b1, 1'b1, 32'h1234_5678); step();

    clear(); fe[0][0] = 32'h1000_0000; cf[0][0] = 32'hE800_0000; idat = 32'h0800_0000;
    issue(1'b1, 1'b1, 32'hF000_0000); step();

    clear(); fill_all(32'h0100_0000, 32'h1000_0000);
    issue(1'b1, 1'b1, 32'h2400_0000); step();

    clear(); fe[1][8] = 32'h0000_0001; cf[1][8] = 32'h0800_0000;
    issue(1'b1, 1'b1, 32'h0000_0000); step();

    clear(); fe[1][8] = 32'h0000_0001; cf[1][8] = 32'hF800_0000;
    issue(1'b1, 1'b1, 32'hFFFF_FFFF); step();

    clear(); fill_all(32'h2000_0000, 32'h2000_0000);
    issue(1'b1, 1'b1, 32'h7FFF_FFFF); step();

    clear(); fill_all(32'h2000_0000, 32'hE000_0000);
    issue(1'b1, 1'b1, 32'h8000_0000); step();

    // Hold: load a value, then wiggle inputs with i_valid low.
    clear(); idat = 32'h2000_0000;
    issue(1'b1, 1'b1, 32'h2000_0000); step();
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      issue(1'b0, 1'b0, '0);
      step();
    end
    check("hold_value", bus.o_data, 32'h2000_0000);

    // Asynchronous reset between edges, then held low with i_valid high.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", bus.o_data, '0);
    randomize_inputs();
    issue(1'b1, 1'b0, '0);
    repeat (3) step();
    check("reset_held", bus.o_data, '0);
    rst = 1'b1;
    issue(1'b0, 1'b0, '0);
    step();

    // Random traffic with gaps.
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      issue(($urandom_range(0, 3) != 0), 1'b0, '0);
      step();
    end

    issue(1'b0, 1'b0, '0);
    repeat (3) step();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/svm_mac_pe.md
Name: svm_mac_pe

Overview:
- One processing element of the SVM human-detection systolic chain.
- Each valid cycle it computes the dot product of four 9-bin HOG feature vectors with four 9-bin SVM coefficient vectors, adds the partial sum arriving from the upstream element, and registers the result.
- PEs are cascaded through i_data/o_data; the last PE's sign bit gives the person/no-person decision.

Parameters:
- FEA_I, 4, integer bits of feature, coefficient and partial sum, including the sign bit.
- FEA_F, 28, fractional bits of the same values.
- Derived W = FEA_I+FEA_F (32): lane width. All values are two's-complement fixed point Q(FEA_I.FEA_F).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fea_a  in  9*W  feature vector A; lane k at bits [k*W +: W], k=0..8.
- fea_b  in  9*W  feature vector B, same lane layout.
- fea_c  in  9*W  feature vector C, same lane layout.
- fea_d  in  9*W  feature vector D, same lane layout.
- coef_a  in  9*W  coefficients paired lane-by-lane with fea_a.
- coef_b  in  9*W  coefficients paired lane-by-lane with fea_b.
- coef_c  in  9*W  coefficients paired lane-by-lane with fea_c.
- coef_d  in  9*W  coefficients paired lane-by-lane with fea_d.
- i_data  in  W  upstream partial sum; tie to 0 for the first PE.
- i_valid  in  1  features valid this cycle; qualifies the update.
- o_data  out  W  registered partial sum to the downstream PE.

Behaviour:
- Reset: rst low forces o_data=0 immediately, independent of clk. Reset has priority over i_valid and may be asserted mid-stream; accumulated state is discarded.
- Products: 36 signed products fea_x[k]*coef_x[k] for x in {a,b,c,d}, k in 0..8. Each is a full 2W-bit Q(2I.2F) value.
- Accumulation:
  - Sign-extend each product to at least 2W+6 bits.
  - Sign-extend i_data to the same width and shift it left by FEA_F to align its binary point.
  - Sum all 37 terms exactly, with no intermediate overflow.
- Requantisation:
  - Arithmetic shift the exact sum right by FEA_F. This truncates toward minus infinity, with no rounding.
  - Saturate to W-bit signed: above 2^(W-1)-1 gives 0x7FF..F; below -2^(W-1) gives 0x800..0.
- Update: on a rising clk with rst high and i_valid=1, o_data takes the requantised, saturated value.
- Hold: i_valid=0 leaves o_data unchanged. Input changes while i_valid=0 have no effect.
- Latency: exactly one clock from the i_valid sample to the new o_data. There are no internal pipeline stages, so a chain of N PEs advances one element per valid cycle.
- Purely combinational path from inputs to the next-state value; no combinational path from inputs to o_data.
- No handshake back-pressure; the PE accepts an update every valid cycle.
- Invariant: o_data is always a legal W-bit value. X on unused lanes is not permitted; drivers supply 0 for unused lanes.

Test Plan (FEA_I=4, FEA_F=28; 1.0 = 0x10000000):
- Pass-through: all fea/coef = 0, i_data=0x12345678, i_valid=1 -> o_data=0x12345678 next cycle.
- Single product plus offset: fea_a lane0=0x10000000 (1.0), coef_a lane0=0xE8000000 (-1.5), i_data=0x08000000 (0.5), rest 0 -> o_data=0xF0000000 (-1.0).
- All 36 lanes: fea=0x01000000 (1/16), coef=0x10000000 (1.0), i_data=0 -> o_data=0x24000000 (2.25).
- Truncation toward minus infinity:
  - fea_b lane8=0x00000001 (2^-28), coef_b lane8=0x08000000 (0.5) -> 0x00000000.
  - Same with coef=0xF8000000 (-0.5) -> 0xFFFFFFFF.
- Saturation:
  - All 36 lanes fea=coef=0x20000000 (2.0) -> 0x7FFFFFFF.
  - Same with coef=0xE0000000 (-2.0) -> 0x80000000.
- Hold and reset:
  - After loading 0x20000000, drop i_valid and change inputs -> o_data stays 0x20000000.
  - Then pull rst low between clock edges -> o_data=0 immediately, and it stays 0 while rst is low, even with i_valid=1.
